// File: rtl/sb_spi_host_ctrl_if.sv
// ---------------------------------------------------------------------------
// sb_spi_host_ctrl_if
// System-bus link between the host controller (initiator) and the iCE40UP
// hard SPI block (responder).
//
// Signals:
//   sb_stb_o  initiator -> responder  bus strobe        (SBSTBI)
//   sb_rw_o   initiator -> responder  1 = write         (SBRWI)
//   sb_adr_o  initiator -> responder  register address  (SBADRI7..0)
//   sb_dat_o  initiator -> responder  write data        (SBDATI7..0)
//   sb_dat_i  responder -> initiator  read data         (SBDATO7..0)
//   sb_ack_i  responder -> initiator  acknowledge       (SBACKO)
// Modports: master (host controller), slave (hard SPI or bus model).
// ---------------------------------------------------------------------------
interface sb_spi_host_ctrl_if;
    logic       sb_stb_o;
    logic       sb_rw_o;
    logic [7:0] sb_adr_o;
    logic [7:0] sb_dat_o;
    logic [7:0] sb_dat_i;
    logic       sb_ack_i;

    modport master (
        output sb_stb_o, sb_rw_o, sb_adr_o, sb_dat_o,
        input  sb_dat_i, sb_ack_i
    );

    modport slave (
        input  sb_stb_o, sb_rw_o, sb_adr_o, sb_dat_o,
        output sb_dat_i, sb_ack_i
    );
endinterface

// File: rtl/sb_spi_host_ctrl.sv
// ---------------------------------------------------------------------------
// sb_spi_host_ctrl
// System-bus initiator for the iCE40UP hard SPI block. After reset it
// configures the hard SPI as master (SPICR1, SPIBR, SPICR2), then turns a
// byte stream into register accesses: chip select on, TRDY poll, TX write,
// RRDY poll, RX read, and at frame end TIP poll and chip select off.
//
// Ports:
//   clk, rst            system clock (also SBCLKI), async active-high reset
//   sb                  system bus, master modport of sb_spi_host_ctrl_if
//   tx_data/tx_valid    byte to send; tx_ready pulses when the byte is taken
//   tx_last             marks the final byte of a frame (CS released after)
//   rx_data/rx_valid    received byte, one-cycle pulse, no backpressure
//   init_done           configuration complete (sticky until reset)
//   busy                frame in progress (chip select asserted)
//   err                 sticky bus ack-timeout flag
//
// Optional feature: define SB_SPI_HOST_TIMEOUT_EN to build the per-access
// ack timeout (ACK_TIMEOUT cycles). Without it the controller waits for ack
// indefinitely and err is constant 0.
// ---------------------------------------------------------------------------
module sb_spi_host_ctrl #(
    parameter logic [3:0] BUS_ADDR74  = 4'b0000,
    parameter logic [7:0] SPI_BR      = 8'd3,
    parameter logic [1:0] CPOL_CPHA   = 2'b00,
    parameter logic [3:0] CS_MASK     = 4'b0001,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    sb_spi_host_ctrl_if.master        sb,
    input  logic [7:0]                tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    input  logic                      tx_last,
    output logic [7:0]                rx_data,
    output logic                      rx_valid,
    output logic                      init_done,
    output logic                      busy,
    output logic                      err
);
    localparam logic [3:0] REG_CR1  = 4'h9;
    localparam logic [3:0] REG_CR2  = 4'hA;
    localparam logic [3:0] REG_BR   = 4'hB;
    localparam logic [3:0] REG_SR   = 4'hC;
    localparam logic [3:0] REG_TXDR = 4'hD;
    localparam logic [3:0] REG_RXDR = 4'hE;
    localparam logic [3:0] REG_CSR  = 4'hF;

    typedef enum logic [3:0] {
        S_INIT_CR1, S_INIT_BR, S_INIT_CR2, S_IDLE, S_CS_ON, S_POLL_T,
        S_WR_TX, S_POLL_R, S_RD_RX, S_POLL_TIP, S_CS_OFF
    } state_t;

    state_t     state_q;
    logic       stb_q, rw_q, last_q;
    logic [7:0] adr_q, dat_q;
    logic       tx_ready_q, rx_valid_q, init_done_q, busy_q, err_q;
    logic [7:0] rx_data_q;

    // Access each state performs once the bus has had its idle cycle.
    logic       acc_en, acc_rw;
    logic [3:0] acc_reg;
    logic [7:0] acc_dat;
    logic       timeout;

    always_comb begin
        acc_en  = 1'b1;
        acc_rw  = 1'b0;
        acc_reg = 4'h0;
        acc_dat = 8'h00;
        case (state_q)
            S_INIT_CR1: begin acc_rw = 1'b1; acc_reg = REG_CR1; acc_dat = 8'h80; end
            S_INIT_BR:  begin acc_rw = 1'b1; acc_reg = REG_BR;  acc_dat = SPI_BR; end
            S_INIT_CR2: begin
                acc_rw  = 1'b1;
                acc_reg = REG_CR2;
                acc_dat = {1'b1, 1'b1, 3'b000, CPOL_CPHA, 1'b0};
            end
            S_CS_ON:    begin acc_rw = 1'b1; acc_reg = REG_CSR; acc_dat = {4'b0000, CS_MASK}; end
            // A stalled stream keeps CS asserted but generates no bus traffic.
            S_POLL_T:   begin acc_reg = REG_SR; acc_en = tx_valid; end
            S_WR_TX:    begin acc_rw = 1'b1; acc_reg = REG_TXDR; acc_dat = tx_data; end
            S_POLL_R:   acc_reg = REG_SR;
            S_RD_RX:    acc_reg = REG_RXDR;
            S_POLL_TIP: acc_reg = REG_SR;
            S_CS_OFF:   begin acc_rw = 1'b1; acc_reg = REG_CSR; acc_dat = 8'h00; end
            default:    acc_en = 1'b0;
        endcase
    end

`ifdef SB_SPI_HOST_TIMEOUT_EN
    logic [7:0] to_cnt_q;

    // Counts strobe cycles without ack; cleared whenever the strobe is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cnt_q <= 8'd0;
        else if (!stb_q)
            to_cnt_q <= 8'd0;
        else if (!sb.sb_ack_i)
            to_cnt_q <= to_cnt_q + 8'd1;
    end

    assign timeout = stb_q && !sb.sb_ack_i && (to_cnt_q == 8'(ACK_TIMEOUT - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (ACK_TIMEOUT != 0);
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT_CR1;
            stb_q       <= 1'b0;
            rw_q        <= 1'b0;
            adr_q       <= 8'h00;
            dat_q       <= 8'h00;
            last_q      <= 1'b0;
            tx_ready_q  <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            if (!stb_q) begin
                // Strobe low: this is the mandatory idle cycle; launch here.
                if (state_q == S_IDLE) begin
                    if (init_done_q && tx_valid) begin
                        state_q <= S_CS_ON;
                        busy_q  <= 1'b1;
                    end
                end else if (acc_en) begin
                    stb_q <= 1'b1;
                    rw_q  <= acc_rw;
                    adr_q <= {BUS_ADDR74, acc_reg};
                    dat_q <= acc_dat;
                    if (state_q == S_WR_TX) begin
                        tx_ready_q <= 1'b1;
                        last_q     <= tx_last;
                    end
                end
            end else if (sb.sb_ack_i) begin
                stb_q <= 1'b0;
                case (state_q)
                    S_INIT_CR1: state_q <= S_INIT_BR;
                    S_INIT_BR:  state_q <= S_INIT_CR2;
                    S_INIT_CR2: begin
                        state_q     <= S_IDLE;
                        init_done_q <= 1'b1;
                    end
                    S_CS_ON:    state_q <= S_POLL_T;
                    S_POLL_T:   if (sb.sb_dat_i[4]) state_q <= S_WR_TX;
                    S_WR_TX:    state_q <= S_POLL_R;
                    S_POLL_R:   if (sb.sb_dat_i[3]) state_q <= S_RD_RX;
                    S_RD_RX: begin
                        rx_data_q  <= sb.sb_dat_i;
                        rx_valid_q <= 1'b1;
                        state_q    <= last_q ? S_POLL_TIP : S_POLL_T;
                    end
                    S_POLL_TIP: if (!sb.sb_dat_i[7]) state_q <= S_CS_OFF;
                    S_CS_OFF: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default:    state_q <= S_INIT_CR1;
                endcase
            end else if (timeout) begin
                // Abandon the access; try to release CS once, then give up.
                stb_q <= 1'b0;
                err_q <= 1'b1;
                if (state_q == S_CS_OFF) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    state_q <= S_CS_OFF;
                end
            end
        end
    end

    assign sb.sb_stb_o = stb_q;
    assign sb.sb_rw_o  = rw_q;
    assign sb.sb_adr_o = adr_q;
    assign sb.sb_dat_o = dat_q;
    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign init_done   = init_done_q;
    assign busy        = busy_q;
    assign err         = err_q;
endmodule

// File: tb/tb_sb_spi_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sb_spi_host_ctrl
// Directed bench for sb_spi_host_ctrl. A zero-wait bus responder models the
// hard SPI: SPISR reports TRDY/RRDY (TIP always 0), SPIRXDR returns the last
// SPITXDR byte plus 0x97. Every bus transfer and received byte is logged.
// ---------------------------------------------------------------------------
module tb_sb_spi_host_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready, rx_valid, init_done, busy, err;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    sb_spi_host_ctrl_if bus ();

    sb_spi_host_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .sb        (bus),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .init_done (init_done),
        .busy      (busy),
        .err       (err)
    );

    int errors = 0;
    int checks = 0;

    // Responder model
    logic       nack_tx = 1'b0;
    logic       rrdy_en = 1'b1;
    int         sr_reads = 0;
    int         hold_start = 0;
    int         hold_n = 0;
    logic [7:0] last_tx = 8'h00;
    logic [7:0] rdat;
    logic       trdy;

    assign trdy = !(sr_reads >= hold_start && sr_reads < hold_start + hold_n);

    always_comb begin
        rdat = 8'h00;
        if (bus.sb_adr_o[3:0] == 4'hC)
            rdat = {1'b0, 2'b00, trdy, rrdy_en, 3'b000};
        else if (bus.sb_adr_o[3:0] == 4'hE)
            rdat = last_tx + 8'h97;
    end

    assign bus.sb_dat_i = rdat;
    assign bus.sb_ack_i = bus.sb_stb_o && !(nack_tx && bus.sb_adr_o[3:0] == 4'hD);

    always @(posedge clk) begin
        if (bus.sb_stb_o && bus.sb_ack_i) begin
            if (!bus.sb_rw_o && bus.sb_adr_o[3:0] == 4'hC)
                sr_reads <= sr_reads + 1;
            if (bus.sb_rw_o && bus.sb_adr_o[3:0] == 4'hD)
                last_tx <= bus.sb_dat_o;
        end
    end

    // Transaction log: {rw, adr, data}
    logic [16:0] blog[$];
    logic [7:0]  rxq[$];
    int          tx_stb_cycles = 0;

    always @(negedge clk) begin
        if (bus.sb_stb_o && bus.sb_ack_i) begin
            blog.push_back({bus.sb_rw_o, bus.sb_adr_o, bus.sb_rw_o ? bus.sb_dat_o : bus.sb_dat_i});
            $display("bus %s adr=%02h dat=%02h", bus.sb_rw_o ? "WR" : "RD", bus.sb_adr_o,
                     bus.sb_rw_o ? bus.sb_dat_o : bus.sb_dat_i);
        end
        if (bus.sb_stb_o && bus.sb_rw_o && bus.sb_adr_o[3:0] == 4'hD)
            tx_stb_cycles = tx_stb_cycles + 1;
        if (rx_valid) begin
            rxq.push_back(rx_data);
            $display("rx byte %02h", rx_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] log_at(input int idx);
        if (idx < 0 || idx >= blog.size()) return 17'h1FFFF;
        return blog[idx];
    endfunction

    function automatic int log_count(input logic rw, input logic [3:0] rg);
        int n = 0;
        foreach (blog[i])
            if (blog[i][16] == rw && blog[i][11:8] == rg) n++;
        return n;
    endfunction

    function automatic logic [7:0] rx_at(input int idx);
        if (idx < 0 || idx >= rxq.size()) return 8'hXX;
        return rxq[idx];
    endfunction

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        bit got = 1'b0;
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (tx_ready) got = 1'b1;
        end
        if (got) begin
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        chk($sformatf("tx_ready for %02h", d), {31'd0, got}, 32'd1);
    endtask

    task automatic wait_busy_low(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 300);
        chk({tag, " busy low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (init_done !== 1'b1 && n < 100);
        chk({tag, " init_done"}, {31'd0, init_done}, 32'd1);
    endtask

    function automatic logic [31:0] all_outputs();
        return {1'b0, bus.sb_stb_o, bus.sb_rw_o, bus.sb_adr_o, bus.sb_dat_o, tx_ready,
                rx_data, rx_valid, init_done, busy, err};
    endfunction

    initial begin
        logic [16:0] exp_init [3];
        logic [16:0] exp_single [7];
        int          base;

        exp_init   = '{17'h1_0980, 17'h1_0B03, 17'h1_0AC0};
        exp_single = '{17'h1_0F01, 17'h0_0C18, 17'h1_0DA5, 17'h0_0C18,
                       17'h0_0E3C, 17'h0_0C18, 17'h1_0F00};

        // Reset state and init sequence
        wait_cycles(3);
        chk("reset outputs", all_outputs(), 32'd0);
        rst = 1'b0;
        wait_init("init");
        chk("init access count", blog.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("init access %0d", i), {15'd0, log_at(i)}, {15'd0, exp_init[i]});
        chk("busy idle after init", {31'd0, busy}, 32'd0);

        // Single byte frame: 0xA5 out, 0x3C back
        blog.delete();
        rxq.delete();
        send_byte(8'hA5, 1'b1);
        chk("busy during frame", {31'd0, busy}, 32'd1);
        wait_busy_low("single");
        chk("single access count", blog.size(), 32'd7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("single access %0d", i), {15'd0, log_at(i)}, {15'd0, exp_single[i]});
        chk("single rx count", rxq.size(), 32'd1);
        chk("single rx data", {24'd0, rx_at(0)}, 32'h3C);

        // Three byte frame, TRDY low for 5 polls before byte 2
        blog.delete();
        rxq.delete();
        hold_start = sr_reads + 2;
        hold_n     = 5;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        wait_busy_low("three");
        chk("three SPISR reads", log_count(1'b0, 4'hC), 32'd12);
        chk("three SPICSR writes", log_count(1'b1, 4'hF), 32'd2);
        chk("three SPITXDR writes", log_count(1'b1, 4'hD), 32'd3);
        chk("three CS on", {15'd0, log_at(0)}, 32'h1_0F01);
        chk("three CS off", {15'd0, log_at(blog.size() - 1)}, 32'h1_0F00);
        chk("three rx count", rxq.size(), 32'd3);
        chk("three rx 0", {24'd0, rx_at(0)}, 32'hA8);
        chk("three rx 1", {24'd0, rx_at(1)}, 32'hB9);
        chk("three rx 2", {24'd0, rx_at(2)}, 32'hCA);

        // Stream stall: tx_valid low for 20 cycles mid-frame
        blog.delete();
        rxq.delete();
        send_byte(8'h44, 1'b0);
        for (int i = 0; i < 100 && rxq.size() == 0; i++) @(negedge clk);
        chk("stall first rx", rxq.size(), 32'd1);
        wait_cycles(2);
        base = blog.size();
        wait_cycles(20);
        chk("stall no bus traffic", blog.size(), base);
        chk("stall busy held", {31'd0, busy}, 32'd1);
        chk("stall strobe low", {31'd0, bus.sb_stb_o}, 32'd0);
        send_byte(8'h55, 1'b1);
        wait_busy_low("stall");
        chk("stall access count", blog.size(), 32'd11);
        chk("stall SPICSR writes", log_count(1'b1, 4'hF), 32'd2);
        chk("stall rx 0", {24'd0, rx_at(0)}, 32'hDB);
        chk("stall rx 1", {24'd0, rx_at(1)}, 32'hEC);

        // Ack withheld on the SPITXDR write
        blog.delete();
        rxq.delete();
        nack_tx = 1'b1;
        base    = tx_stb_cycles;
`ifdef SB_SPI_HOST_TIMEOUT_EN
        send_byte(8'h66, 1'b1);
        wait_busy_low("timeout");
        nack_tx = 1'b0;
        chk("timeout strobe cycles", tx_stb_cycles - base, 32'd15);
        chk("timeout err", {31'd0, err}, 32'd1);
        chk("timeout CS off", {15'd0, log_at(blog.size() - 1)}, 32'h1_0F00);
        chk("timeout strobe low", {31'd0, bus.sb_stb_o}, 32'd0);
        chk("timeout rx discarded", rxq.size(), 32'd0);
`else
        send_byte(8'h66, 1'b1);
        wait_cycles(30);
        chk("no-timeout strobe held", {31'd0, bus.sb_stb_o}, 32'd1);
        chk("no-timeout addr", {24'd0, bus.sb_adr_o}, 32'h0D);
        chk("no-timeout long wait", {31'd0, (tx_stb_cycles - base) >= 30}, 32'd1);
        chk("no-timeout err", {31'd0, err}, 32'd0);
        nack_tx = 1'b0;
        wait_busy_low("no-timeout");
        chk("no-timeout rx data", {24'd0, rx_at(0)}, 32'hFD);
        chk("no-timeout err after", {31'd0, err}, 32'd0);
`endif

        // Reset while polling RRDY
        rrdy_en = 1'b0;
        send_byte(8'h77, 1'b1);
        wait_cycles(8);
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset outputs", all_outputs(), 32'd0);
        rrdy_en = 1'b1;
        wait_cycles(2);
        blog.delete();
        rst = 1'b0;
        wait_init("re-init");
        chk("re-init access count", blog.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("re-init access %0d", i), {15'd0, log_at(i)}, {15'd0, exp_init[i]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
